// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg: shared definitions for the data-memory responder.
//   - RV64 load/store funct3 size/sign codes
//   - responder FSM state encoding (2 bits)
//   - byte-mask width of one 64-bit storage word
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  localparam int BYTE_MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rv_dmem_lane.sv
// ---------------------------------------------------------------------------
// rv_dmem_lane: combinational byte-lane steering for one 64-bit word.
// Ports:
//   funct3_i     load/store size/sign code
//   offset_i     byte offset inside the word (addr[2:0])
//   wdata_i      right-aligned store data
//   rword_i      current storage word
//   byte_mask_o  store byte enables, shifted to the offset
//   wdata_o      store data shifted into its byte lanes
//   rdata_o      load result: word shifted down, then sign/zero extended
//   misaligned_o access does not sit on its natural size boundary
// ---------------------------------------------------------------------------
module rv_dmem_lane
  import rv_pkg::*;
(
  input  logic [2:0]             funct3_i,
  input  logic [2:0]             offset_i,
  input  logic [63:0]            wdata_i,
  input  logic [63:0]            rword_i,
  output logic [BYTE_MASK_W-1:0] byte_mask_o,
  output logic [63:0]            wdata_o,
  output logic [63:0]            rdata_o,
  output logic                   misaligned_o
);

  logic [5:0]             shamt;
  logic [BYTE_MASK_W-1:0] base_mask;
  logic [63:0]            rsh;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    shamt        = {offset_i, 3'b000};
    base_mask    = 8'h01;
    misaligned_o = 1'b0;
    rdata_o      = '0;

    // funct3[1:0] encodes the access size for both loads and stores.
    unique case (funct3_i[1:0])
      2'd0: begin base_mask = 8'h01; misaligned_o = 1'b0;          end
      2'd1: begin base_mask = 8'h03; misaligned_o = offset_i[0];   end
      2'd2: begin base_mask = 8'h0F; misaligned_o = |offset_i[1:0]; end
      2'd3: begin base_mask = 8'hFF; misaligned_o = |offset_i;     end
    endcase

    byte_mask_o = base_mask << offset_i;
    wdata_o     = wdata_i << shamt;
    rsh         = rword_i >> shamt;

    case (funct3_i)
      F3_B:    rdata_o = {{56{rsh[7]}},  rsh[7:0]};
      F3_H:    rdata_o = {{48{rsh[15]}}, rsh[15:0]};
      F3_W:    rdata_o = {{32{rsh[31]}}, rsh[31:0]};
      F3_D:    rdata_o = rsh;
      F3_BU:   rdata_o = {56'd0, rsh[7:0]};
      F3_HU:   rdata_o = {48'd0, rsh[15:0]};
      F3_WU:   rdata_o = {32'd0, rsh[31:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_dmem_resp.sv
// ---------------------------------------------------------------------------
// rv_dmem_resp: data-memory responder for the core's load/store port.
// Accepts one request at a time (valid/ready), waits LATENCY cycles, performs
// the access on a 64-bit-word storage array and returns the result on a
// second valid/ready handshake.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_valid_i/ready_o    request handshake
//   req_we_i               1 = store, 0 = load
//   req_addr_i             byte address
//   req_funct3_i           RV64 load/store funct3
//   req_wdata_i            right-aligned store data
//   resp_valid_o/ready_i   response handshake
//   resp_rdata_o           extended load data (0 for stores and errors)
//   resp_err_o             misaligned, out of range or illegal funct3
// Optional build macro RV_DMEM_STATS_EN adds stat_loads_o, stat_stores_o and
// stat_errs_o: 32-bit wrapping counters bumped on the response handshake.
// ---------------------------------------------------------------------------
module rv_dmem_resp
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
`ifdef RV_DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads_o,
  output logic [31:0] stat_stores_o,
  output logic [31:0] stat_errs_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [63:0] addr_q;
  logic [2:0]  f3_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic                   req_hs, resp_hs, access;
  logic [IDX_W-1:0]       idx;
  logic                   out_of_range, illegal_f3, misaligned, acc_err;
  logic [63:0]            rword, wsh, load_ext, merged;
  logic [BYTE_MASK_W-1:0] byte_mask;
  logic                   mem_we;

  assign req_hs  = req_valid_i & req_ready_o;
  assign resp_hs = resp_valid_o & resp_ready_i;
  assign access  = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  assign idx          = addr_q[IDX_W+2:3];
  assign out_of_range = |addr_q[63:IDX_W+3];
  assign illegal_f3   = we_q ? f3_q[2] : (f3_q == 3'd7);
  assign acc_err      = misaligned | out_of_range | illegal_f3;
  assign rword        = mem[idx];

  rv_dmem_lane u_lane (
    .funct3_i     (f3_q),
    .offset_i     (addr_q[2:0]),
    .wdata_i      (wdata_q),
    .rword_i      (rword),
    .byte_mask_o  (byte_mask),
    .wdata_o      (wsh),
    .rdata_o      (load_ext),
    .misaligned_o (misaligned)
  );

  // Read-modify-write: only the enabled lanes take new data.
  always_comb begin
    merged = rword;
    for (int b = 0; b < BYTE_MASK_W; b++) begin
      if (byte_mask[b]) merged[8*b +: 8] = wsh[8*b +: 8];
    end
  end

  // Reset wins over a same-cycle access, so an aborted store never lands.
  assign mem_we = access & we_q & ~acc_err & ~rst;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_o  = (state_q == ST_IDLE);
    resp_valid_o = (state_q == ST_RESP);
    unique case (state_q)
      ST_IDLE: if (req_hs) begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
               else               cnt_d   = cnt_q - 4'd1;
      ST_RESP: if (resp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_hs) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        f3_q    <= req_funct3_i;
        wdata_q <= req_wdata_i;
      end
      if (access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || we_q) ? 64'd0 : load_ext;
      end
    end
  end

  // NOTE: the storage array has no reset; it maps onto plain RAM and its
  // contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= merged;
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

`ifdef RV_DMEM_STATS_EN
  logic [31:0] loads_q, stores_q, errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (resp_hs) begin
      if (err_q)     errs_q   <= errs_q + 32'd1;
      else if (we_q) stores_q <= stores_q + 32'd1;
      else           loads_q  <= loads_q + 32'd1;
    end
  end

  assign stat_loads_o  = loads_q;
  assign stat_stores_o = stores_q;
  assign stat_errs_o   = errs_q;
`endif

endmodule
